// File: rtl/branch_cache_updater_if.sv
// rtl/branch_cache_updater_if.sv - EX update channel and cache prev-read/write port bundle
interface branch_cache_updater_if #(
  parameter int WIDTH = 16
);
  logic             upd_valid;
  logic             upd_ready;
  logic [2:0]       upd_idx;
  logic             upd_taken;
  logic [WIDTH-3:0] upd_target;
  logic [2:0]       rd_idx;
  logic [WIDTH-1:0] rd_data;
  logic             wr_en;
  logic [2:0]       wr_idx;
  logic [WIDTH-1:0] wr_data;
  logic             busy;

  // EX stage and the cache array
  modport master (
    output upd_valid, upd_idx, upd_taken, upd_target, rd_data,
    input  upd_ready, rd_idx, wr_en, wr_idx, wr_data, busy
  );

  // the updater
  modport slave (
    input  upd_valid, upd_idx, upd_taken, upd_target, rd_data,
    output upd_ready, rd_idx, wr_en, wr_idx, wr_data, busy
  );
endinterface

// File: rtl/branch_cache_updater.sv
// rtl/branch_cache_updater.sv - queued read-modify-write updater for the 8-entry branch cache (option: BRCACHE_HYST_EN)
module branch_cache_updater #(
  parameter int WIDTH      = 16,
  parameter int FIFO_DEPTH = 4
) (
  input logic                   clk,
  input logic                   rst_n,
  branch_cache_updater_if.slave bus
);
  localparam int TW = WIDTH - 2;
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2
  } state_t;

  state_t          state;
  logic [2:0]      q_idx    [FIFO_DEPTH];
  logic            q_taken  [FIFO_DEPTH];
  logic [TW-1:0]   q_target [FIFO_DEPTH];
  logic [PW-1:0]   head;
  logic [PW-1:0]   tail;
  logic [CW-1:0]   count;
  logic [CW-1:0]   count_next;
  logic            ready_q;
  logic            wr_en_q;
  logic [2:0]      cur_idx;
  logic            cur_taken;
  logic [TW-1:0]   cur_target;
  logic [WIDTH-1:0] old;
  logic            push;
  logic            pop;
  logic [1:0]      old_ctr;
  logic [1:0]      new_ctr;
  logic [TW-1:0]   new_target;

  // ready is registered, so a full queue never takes a push even if it pops this cycle
  assign push = bus.upd_valid & ready_q;
  assign pop  = ((state == IDLE) || (state == WRITE)) && (count != '0);

  // queue occupancy after this cycle's push and pop
  always_comb begin
    count_next = count;
    if (push && !pop) begin
      count_next = count + CW'(1);
    end else if (!push && pop) begin
      count_next = count - CW'(1);
    end
  end

  // queue storage, written at the tail; contents need no reset
  always_ff @(posedge clk) begin
    if (push) begin
      q_idx[tail]    <= bus.upd_idx;
      q_taken[tail]  <= bus.upd_taken;
      q_target[tail] <= bus.upd_target;
    end
  end

  // pointers, occupancy, current entry and the READ/WRITE sequencer
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      head       <= '0;
      tail       <= '0;
      count      <= '0;
      ready_q    <= 1'b1;
      wr_en_q    <= 1'b0;
      cur_idx    <= '0;
      cur_taken  <= 1'b0;
      cur_target <= '0;
      old        <= '0;
    end else begin
      count   <= count_next;
      ready_q <= (count_next != CW'(FIFO_DEPTH));
      if (push) begin
        tail <= tail + PW'(1);
      end
      if (pop) begin
        head       <= head + PW'(1);
        cur_idx    <= q_idx[head];
        cur_taken  <= q_taken[head];
        cur_target <= q_target[head];
      end
      case (state)
        IDLE: begin
          wr_en_q <= 1'b0;
          if (pop) begin
            state <= READ;
          end
        end
        READ: begin
          old     <= bus.rd_data;
          wr_en_q <= 1'b1;
          state   <= WRITE;
        end
        WRITE: begin
          wr_en_q <= 1'b0;
          state   <= pop ? READ : IDLE;
        end
        default: begin
          wr_en_q <= 1'b0;
          state   <= IDLE;
        end
      endcase
    end
  end

  assign old_ctr = old[WIDTH-1:WIDTH-2];

`ifdef BRCACHE_HYST_EN
  // 2-bit saturating counter: never wraps past 0 or 3
  always_comb begin
    new_ctr = old_ctr;
    if (cur_taken) begin
      if (old_ctr != 2'd3) begin
        new_ctr = old_ctr + 2'd1;
      end
    end else if (old_ctr != 2'd0) begin
      new_ctr = old_ctr - 2'd1;
    end
  end
`else
  // last-outcome predictor: the stored counter plays no part
  logic unused_old_ctr;
  assign unused_old_ctr = ^old_ctr;
  assign new_ctr = {cur_taken, cur_taken};
`endif

  // a not-taken branch keeps whatever target was already cached
  assign new_target = cur_taken ? cur_target : old[TW-1:0];

  assign bus.upd_ready = ready_q;
  assign bus.rd_idx    = cur_idx;
  assign bus.wr_en     = wr_en_q;
  assign bus.wr_idx    = wr_en_q ? cur_idx : 3'd0;
  assign bus.wr_data   = wr_en_q ? {new_ctr, new_target} : '0;
  assign bus.busy      = (count != '0) || (state != IDLE);
endmodule

// File: tb/tb_branch_cache_updater.sv
// tb/tb_branch_cache_updater.sv - randomized and directed bench for branch_cache_updater
module tb_branch_cache_updater;
  localparam int W = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  branch_cache_updater_if #(.WIDTH(W)) bus ();

  branch_cache_updater #(.WIDTH(W), .FIFO_DEPTH(4)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  // cache array model: combinational prev-read, write at rising edge
  logic [W-1:0] cache [8];
  logic         pl_req = 1'b0;
  logic [2:0]   pl_idx = 3'd0;
  logic [W-1:0] pl_val = '0;
  assign bus.rd_data = cache[bus.rd_idx];

  always @(posedge clk) begin
    if (pl_req) cache[pl_idx] <= pl_val;
    else if (bus.wr_en) cache[bus.wr_idx] <= bus.wr_data;
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [2:0]   idx;
    logic [W-1:0] data;
    int           cyc;
  } obs_t;
  obs_t obs_q[$];
  int   zero_viol = 0;

  // record every write pulse; idle write outputs must read zero
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.wr_en) obs_q.push_back('{bus.wr_idx, bus.wr_data, cyc});
      else if (bus.wr_idx != 3'd0 || bus.wr_data != '0) zero_viol <= zero_viol + 1;
    end
  end

  typedef struct {
    logic [2:0]   idx;
    logic         taken;
    logic [W-3:0] tgt;
  } upd_t;
  upd_t         exp_q[$];
  logic [W-1:0] ref_cache [8];
  int           obs_rd = 0;
  int           n_cmp = 0;
  int           n_err = 0;
  int           acc_cyc [8];

  function automatic logic [W-1:0] ref_next(input logic [W-1:0] prev, input logic taken,
                                            input logic [W-3:0] tgt);
    int c;
    logic [1:0] c2;
    c = int'(prev[W-1:W-2]);
`ifdef BRCACHE_HYST_EN
    if (taken) c = (c < 3) ? c + 1 : 3;
    else c = (c > 0) ? c - 1 : 0;
`else
    c = taken ? 3 : 0;
`endif
    c2 = c[1:0];
    return {c2, (taken ? tgt : prev[W-3:0])};
  endfunction

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    n_cmp++;
    assert (observed === expected) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic preload(input logic [2:0] i, input logic [W-1:0] v);
    @(negedge clk);
    pl_req = 1'b1; pl_idx = i; pl_val = v;
    @(posedge clk);
    #1 pl_req = 1'b0;
    ref_cache[i] = v;
  endtask

  task automatic push(input logic [2:0] i, input logic t, input logic [W-3:0] tg);
    int g;
    g = 0;
    @(negedge clk);
    bus.upd_valid = 1'b1; bus.upd_idx = i; bus.upd_taken = t; bus.upd_target = tg;
    while (!bus.upd_ready && g < 50) begin
      @(negedge clk);
      g++;
    end
    if (g >= 50) check("push_ready_timeout", 32'(bus.upd_ready), 32'd1);
    @(posedge clk);
    exp_q.push_back('{i, t, tg});
    #1 bus.upd_valid = 1'b0;
  endtask

  task automatic drain_check();
    int g;
    g = 0;
    while (bus.busy && g < 400) begin
      @(posedge clk);
      #1 g++;
    end
    check("drain_busy", 32'(bus.busy), 32'd0);
    while (exp_q.size() > 0) begin
      upd_t e;
      e = exp_q.pop_front();
      ref_cache[e.idx] = ref_next(ref_cache[e.idx], e.taken, e.tgt);
      if (obs_rd < obs_q.size()) begin
        check("wr_idx", 32'(obs_q[obs_rd].idx), 32'(e.idx));
        check("wr_data", 32'(obs_q[obs_rd].data), 32'(ref_cache[e.idx]));
        obs_rd++;
      end else begin
        check("write_missing", 32'(obs_q.size()), 32'(obs_rd + 1));
      end
    end
    check("extra_writes", 32'(obs_q.size()), 32'(obs_rd));
    for (int i = 0; i < 8; i++) check($sformatf("cache%0d", i), 32'(cache[i]), 32'(ref_cache[i]));
  endtask

  initial begin
    logic [W-1:0] t1, t2a, t4, t6;
    int s;
`ifdef BRCACHE_HYST_EN
    t1 = 16'h4ABC; t2a = 16'h8123; t4 = 16'h8002; t6 = 16'h8000;
`else
    t1 = 16'hCABC; t2a = 16'h0123; t4 = 16'hC002; t6 = 16'hC000;
`endif
    bus.upd_valid = 1'b0; bus.upd_idx = 3'd0; bus.upd_taken = 1'b0; bus.upd_target = '0;

    // reset state
    for (int i = 0; i < 8; i++) preload(3'(i), '0);
    check("rst_wr_en", 32'(bus.wr_en), 32'd0);
    check("rst_rd_idx", 32'(bus.rd_idx), 32'd0);
    check("rst_wr_idx", 32'(bus.wr_idx), 32'd0);
    check("rst_wr_data", 32'(bus.wr_data), 32'd0);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_ready", 32'(bus.upd_ready), 32'd1);
    @(negedge clk) rst_n = 1'b1;

    // latency: write pulse in the second cycle after the accepting edge
    push(3'd2, 1'b1, 14'h0ABC);
    check("lat_e0_wr_en", 32'(bus.wr_en), 32'd0);
    @(posedge clk); #1;
    check("lat_e1_wr_en", 32'(bus.wr_en), 32'd0);
    check("lat_e1_rd_idx", 32'(bus.rd_idx), 32'd2);
    @(posedge clk); #1;
    check("lat_e2_wr_en", 32'(bus.wr_en), 32'd1);
    check("lat_e2_wr_idx", 32'(bus.wr_idx), 32'd2);
    check("lat_e2_wr_data", 32'(bus.wr_data), 32'(t1));
    drain_check();

    // counter floor/ceiling and target retention
    preload(3'd3, 16'hC123);
    preload(3'd4, 16'h0123);
    preload(3'd6, 16'hC123);
    push(3'd3, 1'b0, 14'h0FFF);
    push(3'd4, 1'b0, 14'h0FFF);
    push(3'd6, 1'b1, 14'h0123);
    drain_check();
    check("nt_dec", 32'(cache[3]), 32'(t2a));
    check("nt_floor", 32'(cache[4]), 32'h0123);
    check("tk_ceil", 32'(cache[6]), 32'hC123);

    // back-to-back burst from idle: queue fills on the 7th, 8th waits one cycle
    s = obs_q.size();
    for (int k = 0; k < 8; k++) begin
      push(3'($urandom_range(0, 7)), 1'($urandom), 14'($urandom));
      acc_cyc[k] = cyc;
    end
    for (int k = 1; k < 8; k++)
      check($sformatf("burst_accept%0d", k), 32'(acc_cyc[k] - acc_cyc[0]), 32'((k == 7) ? 8 : k));
    drain_check();
    check("burst_first_lat", 32'(obs_q[s].cyc - acc_cyc[0]), 32'd2);
    for (int k = 0; k < 7; k++)
      check($sformatf("burst_gap%0d", k), 32'(obs_q[s+k+1].cyc - obs_q[s+k].cyc), 32'd2);

    // same index twice: second read sees the first write
    preload(3'd5, 16'h0000);
    push(3'd5, 1'b1, 14'h0001);
    push(3'd5, 1'b1, 14'h0002);
    drain_check();
    check("same_idx", 32'(cache[5]), 32'(t4));

    // reset during WRITE aborts the write
    preload(3'd1, 16'h1234);
    push(3'd1, 1'b1, 14'h0007);
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("abort_pre_wr_en", 32'(bus.wr_en), 32'd1);
    #1 rst_n = 1'b0;
    #1;
    check("abort_wr_en", 32'(bus.wr_en), 32'd0);
    check("abort_busy", 32'(bus.busy), 32'd0);
    check("abort_ready", 32'(bus.upd_ready), 32'd1);
    exp_q.delete();
    obs_rd = obs_q.size();
    @(posedge clk); @(posedge clk); #1;
    check("abort_entry", 32'(cache[1]), 32'h1234);
    @(negedge clk) rst_n = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    check("post_rst_busy", 32'(bus.busy), 32'd0);
    check("post_rst_ready", 32'(bus.upd_ready), 32'd1);
    check("post_rst_nowrite", 32'(obs_q.size()), 32'(obs_rd));

    // counter mode on a weakly-taken entry
    preload(3'd0, 16'h4000);
    push(3'd0, 1'b1, 14'h0000);
    drain_check();
    check("mode_taken", 32'(cache[0]), 32'(t6));
    preload(3'd0, 16'h4000);
    push(3'd0, 1'b0, 14'h0000);
    drain_check();
    check("mode_not_taken", 32'(cache[0]), 32'h0000);

    // random traffic against the reference model
    for (int i = 0; i < 8; i++) preload(3'(i), 16'($urandom));
    for (int n = 0; n < 60; n++) begin
      push(3'($urandom_range(0, 7)), 1'($urandom), 14'($urandom));
      repeat ($urandom_range(0, 2)) @(posedge clk);
    end
    drain_check();

    check("idle_outputs_zero", 32'(zero_viol), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: observed running expected finished");
    $fatal(1, "timeout");
  end
endmodule
